// File: rtl/yc_token_driver.sv
// rtl/yc_token_driver.sv - drives a word bit-serially as dual-rail tokens to a ycfsm cell and collects its answers
//
// Ports:
//   clk, reset            single clock, asynchronous active-high reset
//   s_valid/s_ready       word offer handshake; s_data and s_match latched on accept
//   s_data, s_match       WIDTH-bit words, sent LSB first on in_tok / match_tok
//   in_tok, match_tok     2-bit tokens to the cell (00 empty, 01 V0, 10 V1)
//   out_tok               2-bit token from the cell, asynchronous to clk
//   r_valid/r_ready       result handshake; r_data holds the captured out_tok bits
//   err                   sticky fault flag (timeout or illegal code), cleared only by reset
module yc_token_driver #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic [WIDTH-1:0] s_match,
  output logic [1:0]       in_tok,
  output logic [1:0]       match_tok,
  input  logic [1:0]       out_tok,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [WIDTH-1:0] r_data,
  output logic             err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT - 1);

  localparam logic [1:0] TOK_E   = 2'b00;
  localparam logic [1:0] TOK_V0  = 2'b01;
  localparam logic [1:0] TOK_V1  = 2'b10;
  localparam logic [1:0] TOK_BAD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT_VAL,
    ST_WAIT_EMPTY,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t           state;
  logic [1:0]       sync1, sync2, sync3;
  logic [WIDTH-1:0] data_q, match_q;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;

  logic stable, got_val, got_empty, illegal, timeout, go_err;

  function automatic logic [1:0] enc_bit(input logic b);
    return b ? TOK_V1 : TOK_V0;
  endfunction

  // A code only counts once it has survived two consecutive samples past the
  // synchronizer, so single-cycle glitches on out_tok never reach the FSM.
  always_comb begin
    stable    = (sync2 == sync3);
    got_val   = stable && ((sync3 == TOK_V0) || (sync3 == TOK_V1));
    got_empty = stable && (sync3 == TOK_E);
    illegal   = stable && (sync3 == TOK_BAD) && (state != ST_IDLE) && (state != ST_ERR);
    timeout   = (cnt == CNT_MAX) &&
                (((state == ST_WAIT_VAL) && !got_val) ||
                 ((state == ST_WAIT_EMPTY) && !got_empty));
    go_err    = illegal || timeout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      sync1     <= TOK_E;
      sync2     <= TOK_E;
      sync3     <= TOK_E;
      data_q    <= '0;
      match_q   <= '0;
      idx       <= '0;
      cnt       <= '0;
      in_tok    <= TOK_E;
      match_tok <= TOK_E;
      s_ready   <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      err       <= 1'b0;
    end else begin
      sync1 <= out_tok;
      sync2 <= sync1;
      sync3 <= sync2;

      if (go_err || (state == ST_ERR)) begin
        state     <= ST_ERR;
        err       <= 1'b1;
        in_tok    <= TOK_E;
        match_tok <= TOK_E;
        s_ready   <= 1'b0;
        r_valid   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (s_valid && s_ready) begin
              data_q  <= s_data;
              match_q <= s_match;
              idx     <= '0;
              s_ready <= 1'b0;
              state   <= ST_DRIVE;
            end else begin
              s_ready <= 1'b1;
            end
          end

          // Both tokens leave Vempty on the same edge.
          ST_DRIVE: begin
            in_tok    <= enc_bit(data_q[idx]);
            match_tok <= enc_bit(match_q[idx]);
            cnt       <= '0;
            state     <= ST_WAIT_VAL;
          end

          ST_WAIT_VAL: begin
            if (got_val) begin
              r_data[idx] <= (sync3 == TOK_V1);
              in_tok      <= TOK_E;
              match_tok   <= TOK_E;
              cnt         <= '0;
              state       <= ST_WAIT_EMPTY;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          // The next bit is only driven once the cell has returned to empty.
          ST_WAIT_EMPTY: begin
            if (got_empty) begin
              if (idx == LAST_IDX) begin
                r_valid <= 1'b1;
                state   <= ST_DONE;
              end else begin
                idx   <= idx + 1'b1;
                state <= ST_DRIVE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          ST_DONE: begin
            if (r_ready) begin
              r_valid <= 1'b0;
              s_ready <= 1'b1;
              state   <= ST_IDLE;
            end
          end

          default: state <= ST_ERR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_yc_token_driver.sv
// tb/tb_yc_token_driver.sv - self-checking bench for yc_token_driver with an echoing cell model
module tb_yc_token_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] s_data;
  logic [3:0] s_match;
  logic [1:0] in_tok;
  logic [1:0] match_tok;
  logic [1:0] out_tok;
  logic       r_valid;
  logic       r_ready;
  logic [3:0] r_data;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  yc_token_driver #(.WIDTH(4), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_match   (s_match),
    .in_tok    (in_tok),
    .match_tok (match_tok),
    .out_tok   (out_tok),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_data    (r_data),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] enc(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

  // Cell model: echoes in_tok five cycles later, or drives a forced code,
  // with an optional one-cycle V1 glitch.
  logic [1:0] hist [0:5] = '{default: 2'b00};
  bit         cell_force = 1'b0;
  logic [1:0] force_val  = 2'b00;
  bit         glitch_req = 1'b0;

  initial begin
    out_tok = 2'b00;
    forever begin
      @(posedge clk);
      #2;
      for (int k = 5; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = in_tok;
      if (glitch_req) begin
        out_tok    = 2'b10;
        glitch_req = 1'b0;
      end else if (cell_force) begin
        out_tok = force_val;
      end else begin
        out_tok = hist[5];
      end
    end
  end

  // Reference model: queue of accepted words; each word must appear as WIDTH
  // return-to-empty data tokens, then as r_data while r_valid is high.
  logic [3:0] exp_d [$];
  logic [3:0] exp_m [$];
  logic [1:0] tok_log [$];
  bit         mon_en = 1'b0;
  int         tok_idx = 0;
  logic [1:0] prev_in = 2'b00;
  logic       prev_rv = 1'b0;
  logic [3:0] cur_d, cur_m;

  always @(negedge clk) begin
    if (reset) begin
      exp_d.delete();
      exp_m.delete();
      tok_idx = 0;
      prev_in = 2'b00;
      prev_rv = 1'b0;
    end else begin
      if (in_tok != prev_in) tok_log.push_back(in_tok);
      if (mon_en) begin
        check("tok_pair_empty", 32'(in_tok == 2'b00), 32'(match_tok == 2'b00));
        if (in_tok != 2'b00 && prev_in != 2'b00) begin
          check("return_to_empty", 32'(in_tok), 32'(prev_in));
        end else if (in_tok != 2'b00) begin
          if (exp_d.size() == 0 || tok_idx >= 4) begin
            check("tok_unexpected", 32'(in_tok), 32'(0));
          end else begin
            cur_d = exp_d[0];
            cur_m = exp_m[0];
            check("in_tok_bit", 32'(in_tok), 32'(enc(cur_d[tok_idx])));
            check("match_tok_bit", 32'(match_tok), 32'(enc(cur_m[tok_idx])));
            tok_idx++;
          end
        end
        if (r_valid) begin
          if (exp_d.size() == 0) begin
            check("rvalid_unexpected", 32'(r_valid), 32'(0));
          end else begin
            check("r_data_model", 32'(r_data), 32'(exp_d[0]));
            check("bits_before_rvalid", tok_idx, 4);
          end
        end
        if (prev_rv && !r_valid && exp_d.size() > 0) begin
          void'(exp_d.pop_front());
          void'(exp_m.pop_front());
          tok_idx = 0;
        end
        check("err_low", 32'(err), 32'(0));
      end
      prev_in = in_tok;
      prev_rv = r_valid;
    end
  end

  task automatic send_word(input logic [3:0] d, input logic [3:0] m);
    int t = 0;
    @(negedge clk);
    while (!s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) check("send_timeout", 32'(s_ready), 32'(1));
    s_data  = d;
    s_match = m;
    s_valid = 1'b1;
    exp_d.push_back(d);
    exp_m.push_back(m);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = ~d;
    s_match = 4'($urandom);
  endtask

  task automatic wait_rvalid(output bit ok);
    int t = 0;
    while (!r_valid && t < 400) begin
      @(negedge clk);
      t++;
    end
    ok = r_valid;
    if (!ok) check("rvalid_timeout", 32'(r_valid), 32'(1));
  endtask

  task automatic wait_rvalid_low();
    int t = 0;
    while (r_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (r_valid) check("rvalid_drop_timeout", 32'(r_valid), 32'(0));
  endtask

  task automatic run_word(input string name, input logic [3:0] d, input logic [3:0] m);
    bit ok;
    send_word(d, m);
    wait_rvalid(ok);
    if (ok) check(name, 32'(r_data), 32'(d));
    wait_rvalid_low();
  endtask

  // Returns once the edge that drives the first data token has passed.
  task automatic wait_first_token();
    int t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (in_tok == 2'b00 && t < 50);
    if (in_tok == 2'b00) check("token_timeout", 32'(in_tok), 32'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("s_ready_after_reset", 32'(s_ready), 32'(1));
    repeat (8) @(negedge clk);
  endtask

  logic [1:0] exp_seq [0:7] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
  logic [3:0] tbl_d [0:2]   = '{4'b0000, 4'b1111, 4'b0110};
  logic [3:0] tbl_m [0:2]   = '{4'b0101, 4'b0000, 4'b1001};

  initial begin
    bit         ok;
    int         first, lat;
    bit         dropped, rv_seen, stayed, bp_ok;
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = 4'h0;
    s_match = 4'h0;
    r_ready = 1'b1;

    #12;
    check("rst_s_ready", 32'(s_ready), 32'(0));
    check("rst_r_valid", 32'(r_valid), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_in_tok", 32'(in_tok), 32'(0));
    check("rst_r_data", 32'(r_data), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("s_ready_first_edge", 32'(s_ready), 32'(1));
    repeat (3) @(negedge clk);

    // Word 1010 / 1111 with token sequence recorded
    mon_en = 1'b1;
    tok_log.delete();
    send_word(4'b1010, 4'b1111);
    wait_rvalid(ok);
    if (ok) begin
      check("word_a_r_data", 32'(r_data), 32'(4'b1010));
      check("word_a_err", 32'(err), 32'(0));
    end
    wait_rvalid_low();
    check("word_a_tok_count", tok_log.size(), 8);
    for (int i = 0; i < 8 && i < tok_log.size(); i++)
      check($sformatf("word_a_tok_%0d", i), 32'(tok_log[i]), 32'(exp_seq[i]));

    for (int i = 0; i < 3; i++)
      run_word($sformatf("word_tbl_%0d", i), tbl_d[i], tbl_m[i]);

    // Backpressure
    r_ready = 1'b0;
    send_word(4'b1001, 4'b0011);
    wait_rvalid(ok);
    bp_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r_valid !== 1'b1 || r_data !== 4'b1001 || s_ready !== 1'b0) bp_ok = 1'b0;
    end
    check("bp_hold", 32'(bp_ok), 32'(1));
    check("bp_r_data", 32'(r_data), 32'(4'b1001));
    #1;
    r_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_r_valid", 32'(r_valid), 32'(0));
    check("bp_release_s_ready", 32'(s_ready), 32'(1));
    repeat (2) @(negedge clk);

    // One-cycle V1 glitch while waiting for the V0 answer of bit 0
    send_word(4'b0100, 4'b0010);
    wait_first_token();
    glitch_req = 1'b1;
    stayed = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (in_tok !== 2'b01 || err !== 1'b0) stayed = 1'b0;
    end
    check("glitch_ignored", 32'(stayed), 32'(1));
    wait_rvalid(ok);
    if (ok) check("glitch_r_data", 32'(r_data), 32'(4'b0100));
    wait_rvalid_low();

    // Asynchronous reset mid-word
    send_word(4'b0110, 4'b1100);
    wait_first_token();
    repeat (3) @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_in_tok", 32'(in_tok), 32'(0));
    check("mid_rst_match_tok", 32'(match_tok), 32'(0));
    check("mid_rst_s_ready", 32'(s_ready), 32'(0));
    check("mid_rst_r_valid", 32'(r_valid), 32'(0));
    check("mid_rst_err", 32'(err), 32'(0));
    check("mid_rst_r_data", 32'(r_data), 32'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_s_ready_release", 32'(s_ready), 32'(1));
    rv_seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (r_valid) rv_seen = 1'b1;
    end
    check("mid_rst_no_partial", 32'(rv_seen), 32'(0));

    // Timeout: the cell never answers
    mon_en     = 1'b0;
    cell_force = 1'b1;
    force_val  = 2'b00;
    send_word(4'b0001, 4'b0001);
    wait_first_token();
    first   = 0;
    dropped = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (err && first == 0) first = k;
      if (first != 0 && !err) dropped = 1'b1;
    end
    check("timeout_latency", first, 16);
    check("timeout_sticky", 32'(dropped), 32'(0));
    check("timeout_err", 32'(err), 32'(1));
    check("timeout_in_tok", 32'(in_tok), 32'(0));
    check("timeout_match_tok", 32'(match_tok), 32'(0));
    check("timeout_s_ready", 32'(s_ready), 32'(0));
    check("timeout_r_valid", 32'(r_valid), 32'(0));
    do_reset();
    check("err_cleared_by_reset", 32'(err), 32'(0));

    // Illegal code 2'b11 during WAIT_VAL
    send_word(4'b1011, 4'b0110);
    wait_first_token();
    force_val = 2'b11;
    lat     = 0;
    rv_seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (err && lat == 0) lat = k;
      if (r_valid) rv_seen = 1'b1;
    end
    check("illegal_err_within_4", 32'(lat >= 1 && lat <= 4), 32'(1));
    check("illegal_no_rvalid", 32'(rv_seen), 32'(0));
    check("illegal_in_tok", 32'(in_tok), 32'(0));
    force_val = 2'b00;
    do_reset();

    // Normal operation after recovery
    cell_force = 1'b0;
    repeat (8) @(negedge clk);
    mon_en = 1'b1;
    run_word("word_after_recovery", 4'b1100, 4'b0011);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/yc_token_driver.md
YC_TOKEN_DRIVER -- requirements
Module: yc_token_driver

Interface
REQ-001 Parameter WIDTH, default 8, bits per word, LSB first.
REQ-002 Parameter TIMEOUT, default 255, max cycles waited per handshake phase, >=4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; one clock, reset asynchronous active-high.
REQ-005 s_valid  input  1  word offered.
REQ-006 s_ready  output  1  word accepted when s_valid & s_ready at edge.
REQ-007 s_data  input  WIDTH  data bits to present on in_tok.
REQ-008 s_match  input  WIDTH  match bits to present on match_tok.
REQ-009 in_tok  output  2  token to ycfsm in; codes Vempty=2'b00, V0=2'b01, V1=2'b10.
REQ-010 match_tok  output  2  token to ycfsm match; same codes.
REQ-011 out_tok  input  2  ycfsm out, asynchronous to clk; 2'b11 illegal.
REQ-012 r_valid  output  1  result word available.
REQ-013 r_ready  input  1  result consumed when r_valid & r_ready at edge.
REQ-014 r_data  output  WIDTH  captured out_tok values, bit i from bit i handshake.
REQ-015 err  output  1  sticky fault flag.

Function
REQ-016 in_tok, match_tok, s_ready, r_valid, err shall be registered outputs.
REQ-017 out_tok shall pass a 2-flop synchronizer plus a third compare stage; a code is "stable" when stages 2 and 3 are equal.
REQ-018 States: IDLE, DRIVE, WAIT_VAL, WAIT_EMPTY, DONE, ERR.
REQ-019 IDLE: s_ready=1, tokens Vempty; on accept, latch s_data/s_match, bit index=0, go DRIVE.
REQ-020 DRIVE: one cycle later in_tok/match_tok shall change in the same cycle to encode bit i (0->V0, 1->V1); go WAIT_VAL.
REQ-021 WAIT_VAL: on stable V0/V1, write 0/1 to r_data[i], drive both tokens Vempty next cycle, go WAIT_EMPTY.
REQ-022 WAIT_EMPTY: on stable Vempty, if i==WIDTH-1 go DONE, else i+1 and go DRIVE.
REQ-023 Tokens shall never move directly between V0 and V1; every data token is separated by Vempty (return-to-empty).
REQ-024 A new bit shall not be driven until out_tok is stable Vempty.
REQ-025 DONE: r_valid=1, r_data held constant until r_valid & r_ready; then IDLE next cycle; s_ready=0 throughout DONE.
REQ-026 Per-phase counter cleared on entry to WAIT_VAL/WAIT_EMPTY; reaching TIMEOUT without the awaited code shall go ERR.
REQ-027 Stable 2'b11 in any non-IDLE state shall go ERR; in IDLE it is ignored.
REQ-028 ERR: err=1, tokens Vempty, s_ready=0, r_valid=0; exit only by reset.
REQ-029 s_data/s_match changes after accept shall not affect the word in flight.

Reset
REQ-030 reset asserted: immediately, without clk, state=IDLE, in_tok=match_tok=Vempty, s_ready=0, r_valid=0, err=0, r_data=0, synchronizer=Vempty, counters 0.
REQ-031 s_ready shall rise on the first edge after reset deasserts.
REQ-032 reset mid-word shall abandon the word; no partial r_valid.

Verification
REQ-033 Reset: assert reset mid-clock -> all outputs at REQ-030 values before next edge; s_ready=1 one edge after release.
REQ-034 WIDTH=4, s_data=4'b1010, s_match=4'b1111, cell model echoes in_tok on out_tok after 5 cycles -> in_tok sequence V0,E,V1,E,V0,E,V1,E; r_data=4'b1010; r_valid=1; err=0.
REQ-035 Backpressure: r_ready low 20 cycles after DONE -> r_valid and r_data stable, s_ready=0; r_ready high -> IDLE, s_ready=1 next cycle.
REQ-036 Timeout: TIMEOUT=16, model never answers -> err=1 exactly 16 cycles after entering WAIT_VAL, tokens Vempty, stays until reset.
REQ-037 Illegal code: model drives 2'b11 during WAIT_VAL -> err=1 within 4 cycles, r_valid never asserted.
REQ-038 Glitch: 1-cycle V1 pulse on out_tok -> ignored; no capture, no state change.
